// File: rtl/operand_fetch_stage_pkg.sv
// Package riscv_pipe_pkg: shared widths, ID/EX register layout and
// control-bundle field positions for the operand fetch stage.
//
// Build option:
//   WB_BYPASS_EN  defined   -> a same-cycle WB write to a source register is
//                              forwarded (wb_data), no stall.
//                 undefined -> that case raises hazard for one cycle; the
//                              retried read sees the committed register file.
package riscv_pipe_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CTRL_W     = 8;

  typedef logic [XLEN-1:0]       xlen_t;
  typedef logic [REG_ADDR_W-1:0] reg_idx_t;
  typedef logic [CTRL_W-1:0]     ctrl_t;

  // x0 is hard-wired to zero; never forwarded, never a hazard source.
  localparam reg_idx_t ZERO_REG = '0;

  // Control bundle layout. The stage passes the bundle through untouched;
  // the positions live here so EX and later stages decode it consistently.
  localparam int CTRL_ALU_OP_LSB    = 0;
  localparam int CTRL_ALU_OP_MSB    = 3;
  localparam int CTRL_ALU_SRC_B_BIT = 4;
  localparam int CTRL_MEMWRITE_BIT  = 5;
  localparam int CTRL_BRANCH_BIT    = 6;
  localparam int CTRL_JUMP_BIT      = 7;

`ifdef WB_BYPASS_EN
  localparam bit WB_BYPASS = 1'b1;
`else
  localparam bit WB_BYPASS = 1'b0;
`endif

  // ID/EX pipeline register contents.
  typedef struct packed {
    logic     valid;
    xlen_t    pc;
    xlen_t    imm;
    xlen_t    op_a;
    xlen_t    op_b;
    reg_idx_t rd;
    ctrl_t    ctrl;
    logic     memread;
    logic     regwrite;
  } ex_reg_t;

endpackage

// File: rtl/operand_fetch_stage_if.sv
// Interface bundling every non-clock/reset signal of operand_fetch_stage.
//   slave  : the stage itself (consumes decoded instruction, produces ID/EX).
//   master : the surrounding pipeline / environment.
//
// Handshakes (both directions use the same rule): a transfer happens on a
// rising clk edge where valid and ready are both 1. valid must not depend on
// ready. id_ready is combinational and never depends on id_valid. While
// ex_valid=1 and ex_ready=0 every ex_* field is held stable.
// hazard is a debug view of the RAW/load-use stall condition.
interface operand_fetch_stage_if;
  import riscv_pipe_pkg::*;

  logic     id_valid, id_ready;
  xlen_t    id_pc, id_imm;
  ctrl_t    id_ctrl;
  reg_idx_t id_rs1, id_rs2, id_rd;
  logic     id_uses_rs1, id_uses_rs2, id_memread, id_regwrite;

  reg_idx_t read_reg_1, read_reg_2;
  xlen_t    read_data_1, read_data_2;

  logic     exm_valid, exm_regwrite, exm_memread;
  reg_idx_t exm_rd;
  xlen_t    exm_result;

  logic     wb_regwrite;
  reg_idx_t wb_rd;
  xlen_t    wb_data;

  logic     flush;
  logic     ex_ready, ex_valid;
  xlen_t    ex_pc, ex_imm, ex_op_a, ex_op_b;
  reg_idx_t ex_rd;
  ctrl_t    ex_ctrl;
  logic     ex_memread, ex_regwrite;

  logic     hazard;

  modport slave (
    input  id_valid, id_pc, id_imm, id_ctrl, id_rs1, id_rs2, id_rd,
           id_uses_rs1, id_uses_rs2, id_memread, id_regwrite,
           read_data_1, read_data_2,
           exm_valid, exm_regwrite, exm_memread, exm_rd, exm_result,
           wb_regwrite, wb_rd, wb_data, flush, ex_ready,
    output id_ready, read_reg_1, read_reg_2,
           ex_valid, ex_pc, ex_imm, ex_op_a, ex_op_b,
           ex_rd, ex_ctrl, ex_memread, ex_regwrite, hazard
  );

  modport master (
    output id_valid, id_pc, id_imm, id_ctrl, id_rs1, id_rs2, id_rd,
           id_uses_rs1, id_uses_rs2, id_memread, id_regwrite,
           read_data_1, read_data_2,
           exm_valid, exm_regwrite, exm_memread, exm_rd, exm_result,
           wb_regwrite, wb_rd, wb_data, flush, ex_ready,
    input  id_ready, read_reg_1, read_reg_2,
           ex_valid, ex_pc, ex_imm, ex_op_a, ex_op_b,
           ex_rd, ex_ctrl, ex_memread, ex_regwrite, hazard
  );

endinterface

// File: rtl/operand_fetch_stage_forward_mux.sv
// operand_forward_mux: combinational priority select for one source operand.
//   idx        : source register index
//   rf_data    : register file read data for idx
//   exm_*      : EX/MEM stage producer
//   wb_*       : writeback port producer
//   operand    : selected value
//   wb_match   : raw WB write-to-idx indication (used for the stall when WB
//                bypass is not built in; see WB_BYPASS_EN in the package)
// Priority: x0 -> 0, EX/MEM ALU result, WB data (bypass builds only), RF.
module operand_forward_mux
  import riscv_pipe_pkg::*;
(
  input  reg_idx_t idx,
  input  xlen_t    rf_data,
  input  logic     exm_valid,
  input  logic     exm_regwrite,
  input  logic     exm_memread,
  input  reg_idx_t exm_rd,
  input  xlen_t    exm_result,
  input  logic     wb_regwrite,
  input  reg_idx_t wb_rd,
  input  xlen_t    wb_data,
  output xlen_t    operand,
  output logic     wb_match
);

  logic exm_hit;

  always_comb begin
    wb_match = wb_regwrite && (wb_rd == idx);
    // A load in MEM carries an address in exm_result, never forward it.
    exm_hit  = exm_valid && exm_regwrite && !exm_memread && (exm_rd == idx);
    operand  = rf_data;
    if (idx == ZERO_REG) begin
      operand = '0;
    end else if (exm_hit) begin
      operand = exm_result;
    end else if (WB_BYPASS && wb_match) begin
      operand = wb_data;
    end
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: ID->EX stage around the register file read ports.
//   clk, rst (async, active low)
//   bus (operand_fetch_stage_if.slave): decoded instruction in (id_*),
//   register file read port (read_reg_*/read_data_*), forwarding sources
//   (exm_*, wb_*), flush, and the registered ID/EX outputs (ex_*).
// Resolves RAW hazards by forwarding from EX/MEM (and WB when WB_BYPASS_EN
// is defined) and by stalling for loads in EX or MEM. Latency 1 cycle,
// throughput 1 per cycle when hazard free.
module operand_fetch_stage
  import riscv_pipe_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  operand_fetch_stage_if.slave bus
);

  ex_reg_t ex_q;
  xlen_t   op_a, op_b;
  logic    wb_match_1, wb_match_2;
  logic    haz_1, haz_2, hazard, id_ready;

  assign bus.read_reg_1 = bus.id_rs1;
  assign bus.read_reg_2 = bus.id_rs2;

  operand_forward_mux u_fwd_a (
    .idx          (bus.id_rs1),
    .rf_data      (bus.read_data_1),
    .exm_valid    (bus.exm_valid),
    .exm_regwrite (bus.exm_regwrite),
    .exm_memread  (bus.exm_memread),
    .exm_rd       (bus.exm_rd),
    .exm_result   (bus.exm_result),
    .wb_regwrite  (bus.wb_regwrite),
    .wb_rd        (bus.wb_rd),
    .wb_data      (bus.wb_data),
    .operand      (op_a),
    .wb_match     (wb_match_1)
  );

  operand_forward_mux u_fwd_b (
    .idx          (bus.id_rs2),
    .rf_data      (bus.read_data_2),
    .exm_valid    (bus.exm_valid),
    .exm_regwrite (bus.exm_regwrite),
    .exm_memread  (bus.exm_memread),
    .exm_rd       (bus.exm_rd),
    .exm_result   (bus.exm_result),
    .wb_regwrite  (bus.wb_regwrite),
    .wb_rd        (bus.wb_rd),
    .wb_data      (bus.wb_data),
    .operand      (op_b),
    .wb_match     (wb_match_2)
  );

  // A load in EX stalls twice (EX, then MEM), a load in MEM once. Without
  // WB bypass a same-cycle WB write also stalls one cycle so the retried
  // read sees the committed value.
  always_comb begin
    haz_1 = bus.id_uses_rs1 && (bus.id_rs1 != ZERO_REG) &&
            ((ex_q.valid && ex_q.memread && (ex_q.rd == bus.id_rs1)) ||
             (bus.exm_valid && bus.exm_memread && (bus.exm_rd == bus.id_rs1)) ||
             (!WB_BYPASS && wb_match_1));
    haz_2 = bus.id_uses_rs2 && (bus.id_rs2 != ZERO_REG) &&
            ((ex_q.valid && ex_q.memread && (ex_q.rd == bus.id_rs2)) ||
             (bus.exm_valid && bus.exm_memread && (bus.exm_rd == bus.id_rs2)) ||
             (!WB_BYPASS && wb_match_2));
    hazard   = haz_1 || haz_2;
    id_ready = !bus.flush && !hazard && (!ex_q.valid || bus.ex_ready);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q <= '0;
    end else if (bus.flush) begin
      ex_q.valid <= 1'b0;
    end else if (ex_q.valid && !bus.ex_ready) begin
      ex_q <= ex_q;  // downstream stall: operands frozen at capture time
    end else if (bus.id_valid && id_ready) begin
      ex_q.valid    <= 1'b1;
      ex_q.pc       <= bus.id_pc;
      ex_q.imm      <= bus.id_imm;
      ex_q.op_a     <= op_a;
      ex_q.op_b     <= op_b;
      ex_q.rd       <= bus.id_rd;
      ex_q.ctrl     <= bus.id_ctrl;
      ex_q.memread  <= bus.id_memread;
      ex_q.regwrite <= bus.id_regwrite;
    end else begin
      // Bubble: only the fields that can cause side effects are cleared.
      ex_q.valid    <= 1'b0;
      ex_q.memread  <= 1'b0;
      ex_q.regwrite <= 1'b0;
    end
  end

  assign bus.id_ready    = id_ready;
  assign bus.hazard      = hazard;
  assign bus.ex_valid    = ex_q.valid;
  assign bus.ex_pc       = ex_q.pc;
  assign bus.ex_imm      = ex_q.imm;
  assign bus.ex_op_a     = ex_q.op_a;
  assign bus.ex_op_b     = ex_q.op_b;
  assign bus.ex_rd       = ex_q.rd;
  assign bus.ex_ctrl     = ex_q.ctrl;
  assign bus.ex_memread  = ex_q.memread;
  assign bus.ex_regwrite = ex_q.regwrite;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: vector table for forwarding/hazard select,
// hand sequences for load-use, downstream stall, flush and async reset.
module tb_operand_fetch_stage;
  import riscv_pipe_pkg::*;

  localparam int W = 4*XLEN + REG_ADDR_W + CTRL_W + 2;
  typedef logic [255:0] chk_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  operand_fetch_stage_if bus();

  operand_fetch_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input chk_t act, input chk_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input xlen_t pc, input xlen_t imm,
                                        input xlen_t a, input xlen_t b,
                                        input reg_idx_t rd, input ctrl_t ctrl,
                                        input logic mr, input logic rw);
    return {pc, imm, a, b, rd, ctrl, mr, rw};
  endfunction

  // Expected ID/EX contents for the instruction currently driven on id_*.
  function automatic logic [W-1:0] exp_now(input xlen_t a, input xlen_t b);
    return pack(bus.id_pc, bus.id_imm, a, b, bus.id_rd, bus.id_ctrl,
                bus.id_memread, bus.id_regwrite);
  endfunction

  // Scoreboard: a downstream transfer pops and compares; a flush while the
  // EX entry is stalled kills it.
  always @(negedge clk) begin
    if (rst && bus.ex_valid) begin
      if (bus.ex_ready) begin
        if (exp_q.size() == 0) begin
          check("ex_unexpected", chk_t'(1), chk_t'(0));
        end else begin
          check("ex_bundle",
                chk_t'(pack(bus.ex_pc, bus.ex_imm, bus.ex_op_a, bus.ex_op_b,
                            bus.ex_rd, bus.ex_ctrl, bus.ex_memread, bus.ex_regwrite)),
                chk_t'(exp_q.pop_front()));
        end
      end else if (bus.flush && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_valid = 1'b0; bus.id_uses_rs1 = 1'b0; bus.id_uses_rs2 = 1'b0;
    bus.id_memread = 1'b0; bus.id_regwrite = 1'b0;
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rd = '0;
    bus.id_pc = '0; bus.id_imm = '0; bus.id_ctrl = '0;
    bus.read_data_1 = '0; bus.read_data_2 = '0;
    bus.exm_valid = 1'b0; bus.exm_regwrite = 1'b0; bus.exm_memread = 1'b0;
    bus.exm_rd = '0; bus.exm_result = '0;
    bus.wb_regwrite = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
    bus.flush = 1'b0; bus.ex_ready = 1'b1;
  endtask

  task automatic drive_id(input xlen_t pc, input reg_idx_t rs1, input reg_idx_t rs2,
                          input logic u1, input logic u2, input reg_idx_t rd,
                          input logic mr, input logic rw,
                          input xlen_t rd1, input xlen_t rd2);
    bus.id_valid = 1'b1; bus.id_pc = pc; bus.id_rs1 = rs1; bus.id_rs2 = rs2;
    bus.id_uses_rs1 = u1; bus.id_uses_rs2 = u2; bus.id_rd = rd;
    bus.id_memread = mr; bus.id_regwrite = rw;
    bus.id_imm = xlen_t'($urandom()); bus.id_ctrl = ctrl_t'($urandom_range(255));
    bus.read_data_1 = rd1; bus.read_data_2 = rd2;
  endtask

  task automatic set_exm(input logic v, input logic rw, input logic mr,
                         input reg_idx_t rd, input xlen_t res);
    bus.exm_valid = v; bus.exm_regwrite = rw; bus.exm_memread = mr;
    bus.exm_rd = rd; bus.exm_result = res;
  endtask

  task automatic set_wb(input logic rw, input reg_idx_t rd, input xlen_t d);
    bus.wb_regwrite = rw; bus.wb_rd = rd; bus.wb_data = d;
  endtask

  typedef struct {
    reg_idx_t rs1, rs2;
    logic     u1, u2;
    xlen_t    rd1, rd2;
    logic     exm_v, exm_rw, exm_mr;
    reg_idx_t exm_rd;
    xlen_t    exm_res;
    logic     wb_rw;
    reg_idx_t wb_rd;
    xlen_t    wb_d;
    logic     exp_ready;
    xlen_t    exp_a, exp_b;
  } vec_t;

  function automatic vec_t mk(input int rs1, input int rs2, input bit u1, input bit u2,
                              input int rd1, input int rd2,
                              input bit ev, input bit erw, input bit emr,
                              input int erd, input int eres,
                              input bit wrw, input int wrd, input int wd,
                              input bit rdy, input int a, input int b);
    vec_t v;
    v.rs1 = reg_idx_t'(rs1); v.rs2 = reg_idx_t'(rs2); v.u1 = u1; v.u2 = u2;
    v.rd1 = xlen_t'(rd1); v.rd2 = xlen_t'(rd2);
    v.exm_v = ev; v.exm_rw = erw; v.exm_mr = emr;
    v.exm_rd = reg_idx_t'(erd); v.exm_res = xlen_t'(eres);
    v.wb_rw = wrw; v.wb_rd = reg_idx_t'(wrd); v.wb_d = xlen_t'(wd);
    v.exp_ready = rdy; v.exp_a = xlen_t'(a); v.exp_b = xlen_t'(b);
    return v;
  endfunction

  vec_t vecs[13];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic prev_ready;
    int   cap;
    bit   wb = WB_BYPASS;

    //      rs1 rs2 u1 u2 rd1    rd2    ev erw emr erd eres     wrw wrd wd     rdy  a       b
    vecs[0]  = mk(1, 2, 1, 1, 'h1e,  'h2,   0, 0, 0, 0, 0,       0, 0, 0,      1,  'h1e,   'h2);
    vecs[1]  = mk(5, 3, 1, 1, 'h0,   'h33,  1, 1, 0, 5, 'h8,     0, 0, 0,      1,  'h8,    'h33);
    vecs[2]  = mk(0, 3, 1, 1, 'h77,  'h34,  1, 1, 0, 0, 'h8,     0, 0, 0,      1,  'h0,    'h34);
    vecs[3]  = mk(5, 3, 1, 1, 'h11,  'h35,  0, 1, 0, 5, 'h8,     0, 0, 0,      1,  'h11,   'h35);
    vecs[4]  = mk(5, 3, 1, 1, 'h12,  'h36,  1, 0, 0, 5, 'h8,     0, 0, 0,      1,  'h12,   'h36);
    vecs[5]  = mk(7, 7, 1, 1, 'h1,   'h2,   1, 1, 0, 7, 'habc,   0, 0, 0,      1,  'habc,  'habc);
    vecs[6]  = mk(4, 3, 1, 1, 'h40,  'h3,   1, 1, 1, 4, 'hdead,  0, 0, 0,      0,  'h0,    'h0);
    vecs[7]  = mk(4, 3, 0, 1, 'h41,  'h3,   1, 1, 1, 4, 'hdead,  0, 0, 0,      1,  'h41,   'h3);
    vecs[8]  = mk(3, 6, 1, 1, 'h5,   'h10,  0, 0, 0, 0, 0,       1, 6, 'h66,   wb, 'h5,    wb ? 'h66 : 'h10);
    vecs[9]  = mk(8, 2, 1, 1, 'h1,   'h2,   1, 1, 0, 8, 'h88,    1, 8, 'h99,   wb, 'h88,   'h2);
    vecs[10] = mk(0, 2, 1, 1, 'h9,   'h22,  0, 0, 0, 0, 0,       1, 0, 'h5,    1,  'h0,    'h22);
    vecs[11] = mk(3, 3, 1, 1, 'h31,  'h31,  0, 1, 1, 3, 'hbad,   0, 0, 0,      1,  'h31,   'h31);
    vecs[12] = mk(1, 6, 1, 0, 'h7,   'h8,   0, 0, 0, 0, 0,       1, 6, 'h66,   1,  'h7,    wb ? 'h66 : 'h8);

    // ---- reset: outputs cleared while an instruction is offered ----
    idle();
    drive_id(32'h100, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 32'h1e, 32'h2);
    cyc(); cyc();
    @(negedge clk);
    check("reset_ex_valid", chk_t'(bus.ex_valid), chk_t'(0));
    check("reset_ex_fields",
          chk_t'(pack(bus.ex_pc, bus.ex_imm, bus.ex_op_a, bus.ex_op_b,
                      bus.ex_rd, bus.ex_ctrl, bus.ex_memread, bus.ex_regwrite)),
          chk_t'(0));
    cyc();
    idle();
    rst = 1'b1;

    // ---- vector table ----
    prev_ready = 1'b0;
    for (int i = 0; i < 13; i++) begin
      cyc();
      check("vec_ex_valid", chk_t'(bus.ex_valid), chk_t'(prev_ready));
      idle();
      drive_id(xlen_t'(32'h200 + 4*i), vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2,
               reg_idx_t'($urandom_range(31)), 1'b0, 1'($urandom_range(1)),
               vecs[i].rd1, vecs[i].rd2);
      set_exm(vecs[i].exm_v, vecs[i].exm_rw, vecs[i].exm_mr, vecs[i].exm_rd, vecs[i].exm_res);
      set_wb(vecs[i].wb_rw, vecs[i].wb_rd, vecs[i].wb_d);
      @(negedge clk);
      check("vec_id_ready", chk_t'(bus.id_ready), chk_t'(vecs[i].exp_ready));
      check("vec_read_reg", chk_t'({bus.read_reg_1, bus.read_reg_2}),
            chk_t'({vecs[i].rs1, vecs[i].rs2}));
      if (vecs[i].exp_ready) exp_q.push_back(exp_now(vecs[i].exp_a, vecs[i].exp_b));
      prev_ready = vecs[i].exp_ready;
    end
    cyc();
    idle();
    cyc();

    // ---- load-use: load rd=9 then a consumer of x9 ----
    drive_id(32'h400, 5'd1, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 32'h1000, 32'h0);
    @(negedge clk);
    check("lu_load_ready", chk_t'(bus.id_ready), chk_t'(1));
    exp_q.push_back(exp_now(32'h1000, 32'h0));
    cyc();
    check("lu_load_in_ex", chk_t'({bus.ex_valid, bus.ex_memread}), chk_t'(2'b11));
    drive_id(32'h404, 5'd9, 5'd2, 1'b1, 1'b1, 5'd10, 1'b0, 1'b1, 32'h0, 32'h2);
    @(negedge clk);
    check("lu_stall_ex", chk_t'(bus.id_ready), chk_t'(0));
    cyc();
    check("lu_bubble1", chk_t'(bus.ex_valid), chk_t'(0));
    set_exm(1'b1, 1'b1, 1'b1, 5'd9, 32'h1234);
    @(negedge clk);
    check("lu_stall_mem", chk_t'(bus.id_ready), chk_t'(0));
    cyc();
    check("lu_bubble2", chk_t'(bus.ex_valid), chk_t'(0));
    set_exm(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    set_wb(1'b1, 5'd9, 32'hedb);
    cap = 0;
    for (int k = 3; k < 6 && cap == 0; k++) begin
      if (k > 3) begin
        cyc();
        set_wb(1'b0, 5'd0, 32'h0);
        bus.read_data_1 = 32'hedb;
      end
      @(negedge clk);
      if (bus.id_ready) begin
        cap = k;
        exp_q.push_back(exp_now(32'hedb, 32'h2));
      end
    end
    check("lu_capture_cycle", chk_t'(cap), chk_t'(wb ? 3 : 4));
    cyc();
    check("lu_consumer_valid", chk_t'(bus.ex_valid), chk_t'(1));
    idle();
    cyc();

    // ---- downstream stall for 3 cycles ----
    drive_id(32'h500, 5'd1, 5'd2, 1'b1, 1'b1, 5'd11, 1'b0, 1'b1, 32'h100, 32'h101);
    @(negedge clk);
    check("st_x_ready", chk_t'(bus.id_ready), chk_t'(1));
    exp_q.push_back(exp_now(32'h100, 32'h101));
    cyc();
    drive_id(32'h504, 5'd3, 5'd4, 1'b1, 1'b1, 5'd12, 1'b0, 1'b1, 32'h200, 32'h201);
    bus.ex_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      if (j > 0) begin
        cyc();
        set_exm(1'b1, 1'b1, 1'b0, 5'd1, xlen_t'(32'hf00 + j));
        bus.read_data_1 = xlen_t'(32'h300 + j);
      end
      @(negedge clk);
      check("st_id_ready", chk_t'(bus.id_ready), chk_t'(0));
      check("st_hold", chk_t'({bus.ex_valid, bus.ex_pc, bus.ex_op_a}),
            chk_t'({1'b1, 32'h500, 32'h100}));
    end
    cyc();
    set_exm(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    bus.read_data_1 = 32'h200;
    bus.ex_ready = 1'b1;
    @(negedge clk);
    check("st_resume_ready", chk_t'(bus.id_ready), chk_t'(1));
    exp_q.push_back(exp_now(32'h200, 32'h201));
    cyc();
    idle();
    check("st_y_in_ex", chk_t'({bus.ex_valid, bus.ex_pc}), chk_t'({1'b1, 32'h504}));
    cyc();

    // ---- flush while EX is stalled ----
    drive_id(32'h600, 5'd1, 5'd2, 1'b1, 1'b1, 5'd13, 1'b0, 1'b1, 32'h61, 32'h62);
    @(negedge clk);
    exp_q.push_back(exp_now(32'h61, 32'h62));
    cyc();
    drive_id(32'h604, 5'd1, 5'd2, 1'b1, 1'b1, 5'd14, 1'b0, 1'b1, 32'h71, 32'h72);
    bus.ex_ready = 1'b0;
    @(negedge clk);
    check("fl_stall_ready", chk_t'(bus.id_ready), chk_t'(0));
    cyc();
    bus.flush = 1'b1;
    @(negedge clk);
    check("fl_id_ready", chk_t'(bus.id_ready), chk_t'(0));
    cyc();
    check("fl_ex_valid", chk_t'(bus.ex_valid), chk_t'(0));
    idle();
    cyc();

    // ---- asynchronous reset while holding ----
    drive_id(32'h700, 5'd1, 5'd2, 1'b1, 1'b1, 5'd15, 1'b0, 1'b1, 32'h81, 32'h82);
    @(negedge clk);
    exp_q.push_back(exp_now(32'h81, 32'h82));
    cyc();
    idle();
    bus.ex_ready = 1'b0;
    @(negedge clk);
    check("ar_held", chk_t'(bus.ex_valid), chk_t'(1));
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("ar_ex_valid", chk_t'(bus.ex_valid), chk_t'(0));
    check("ar_ex_op_a", chk_t'(bus.ex_op_a), chk_t'(0));
    cyc();
    rst = 1'b1;
    bus.ex_ready = 1'b1;
    cyc();
    cyc();
    check("queue_empty", chk_t'(exp_q.size()), chk_t'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_fetch_stage.md
Name:
operand_fetch_stage

Overview:
- ID→EX pipeline stage wrapped around the register file read ports.
- Drives read_reg_1/read_reg_2 from the decoded instruction and resolves RAW hazards. Forwards from EX/MEM and WB, inserts load-use bubbles, and registers operands into the ID/EX pipeline register under a valid/ready handshake.

Parameters:
- XLEN, 32, datapath width
- REG_ADDR_W, 5, register index width
- CTRL_W, 8, opaque control bundle width, passed through unchanged

Ports:
- clk in 1: clock
- rst in 1: asynchronous, active-low reset
- id_valid in 1, id_ready out 1: upstream handshake
- id_pc in XLEN, id_imm in XLEN, id_ctrl in CTRL_W: decoded fields
- id_rs1 in REG_ADDR_W, id_rs2 in REG_ADDR_W, id_rd in REG_ADDR_W: decoded register indices
- id_uses_rs1 in 1, id_uses_rs2 in 1, id_memread in 1, id_regwrite in 1: decoded flags
- read_reg_1 out REG_ADDR_W, read_reg_2 out REG_ADDR_W: combinational copies of id_rs1/id_rs2
- read_data_1 in XLEN, read_data_2 in XLEN: register file combinational read data
- exm_valid in 1, exm_regwrite in 1, exm_memread in 1, exm_rd in REG_ADDR_W, exm_result in XLEN: EX/MEM stage state
- wb_regwrite in 1, wb_rd in REG_ADDR_W, wb_data in XLEN: same signals that drive the register file write port
- flush in 1: branch/jump redirect
- ex_ready in 1: downstream accept
- ex_valid out 1: ID/EX register valid
- ex_pc out XLEN, ex_imm out XLEN, ex_op_a out XLEN, ex_op_b out XLEN: registered fields and operands
- ex_rd out REG_ADDR_W, ex_ctrl out CTRL_W, ex_memread out 1, ex_regwrite out 1: registered fields

Behaviour:
- Reset:
  - rst low asynchronously clears every ex_* output to 0, including ex_valid.
  - Reset mid-stall or mid-hold discards the held instruction.
- Operand select per source s (rs1 or rs2), highest priority first:
  - idx==0 → 0.
  - exm_valid & exm_regwrite & !exm_memread & exm_rd==idx → exm_result.
  - wb_regwrite & wb_rd==idx → wb_data (only under WB_BYPASS_EN).
  - Otherwise read_data_s.
- hazard is asserted when any of the following holds for a used source with idx!=0:
  - ex_valid & ex_memread & ex_rd==idx. A load in EX gives a 2-cycle total stall.
  - exm_valid & exm_memread & exm_rd==idx. A load in MEM: exm_result is an address, not data.
  - Without WB_BYPASS_EN only: wb_regwrite & wb_rd==idx.
- id_ready = !flush & !hazard & (!ex_valid | ex_ready). This is combinational, with no id_valid dependency.
- Posedge update, first matching row wins:
  - flush → ex_valid<=0. The ID instruction is dropped; upstream also sees id_ready=0.
  - ex_valid & !ex_ready → hold all ex_* registers.
  - id_valid & id_ready → capture id_* fields and selected operands; ex_valid<=1.
  - Otherwise → bubble: ex_valid<=0, ex_memread<=0, ex_regwrite<=0. Other fields are don't-care.
- Latency: 1 cycle ID→EX when hazard-free. Throughput is 1 per cycle.
- flush and ex_ready low together: flush wins.
- Captured operands never change while held, even if forwarding sources change.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: a WB write to the register being read in the same cycle forwards wb_data, giving no penalty.
- Undefined: that case raises hazard for one cycle. The next read sees the committed register file value.

Decomposition:
- Package riscv_pipe_pkg holds: XLEN, REG_ADDR_W, CTRL_W, ctrl-bundle field bit positions, and the ZERO_REG constant.
- Sub-module operand_forward_mux: purely combinational priority select for one operand, instantiated twice.

Test Plan:
- Reset and no-hazard capture:
  - Stimulus: rst low, then release; id add rs1=1, rs2=2, read_data 0x1e/0x2, ex_ready=1.
  - Required: ex_* all 0 during reset; next cycle ex_valid=1, ex_op_a=0x1e, ex_op_b=0x2.
- EX/MEM forwarding: exm_regwrite=1, exm_rd=5, exm_result=0x8, id rs1=5, read_data_1=0x0 → ex_op_a=0x8. The same case with rs1=0 gives ex_op_a=0.
- Load-use: load rd=9 captured, next id uses rs1=9:
  - id_ready=0 for 2 cycles; two bubbles with ex_valid=0.
  - Captured on the 3rd cycle, with wb_data=0xedb.
  - ex_op_a=0xedb with the macro; one extra stall cycle without it.
- Downstream stall: ex_ready=0 for 3 cycles with id_valid=1 → ex_* stable, id_ready=0. The instruction advances the cycle ex_ready returns to 1.
- Flush during stall: flush=1 with ex_valid=1 and ex_ready=0 → ex_valid=0 next cycle, id_ready=0 that cycle.
- Async reset mid-hold: rst low between clock edges → ex_valid falls immediately, without waiting for clk.
